// File: rtl/io_input_stall_controller_if.sv
// io_input_stall_controller_if: decode strobes, raw board inputs and stall/write-back outputs of the IN/HALT controller
interface io_input_stall_controller_if #(
  parameter int SW_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic In;
  logic Halt;
  logic Button;
  logic [SW_WIDTH-1:0] Switches;
  logic ClockEnable;
  logic [DATA_WIDTH-1:0] InData;
  logic InValid;
  logic Waiting;
  logic Halted;
  modport master (
    output In, Halt, Button, Switches,
    input ClockEnable, InData, InValid, Waiting, Halted
  );
  modport slave (
    input In, Halt, Button, Switches,
    output ClockEnable, InData, InValid, Waiting, Halted
  );
endinterface

// File: rtl/io_input_stall_controller.sv
// io_input_stall_controller: stalls the core on IN/HALT, commits IN on a debounced button press; IN_SIGN_EXTEND_EN selects sign extension of InData
module io_input_stall_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input logic clock,
  input logic reset,
  io_input_stall_controller_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {RUN, WAIT, COMMIT, HALTED} state_t;
  state_t r_state, w_next;
  logic r_sync1, r_sync2, r_db, r_press;
  logic [CW-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_data, w_ext;
  logic w_diff, w_flip;
  assign w_diff = r_sync2 != r_db;
  assign w_flip = w_diff && (r_cnt >= CW'(DEBOUNCE_CYCLES - 1));
`ifdef IN_SIGN_EXTEND_EN
  assign w_ext = DATA_WIDTH'($signed(bus.Switches));
`else
  assign w_ext = DATA_WIDTH'(bus.Switches);
`endif
  assign bus.InData = r_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_db <= 1'b1;
      r_press <= 1'b0;
      r_cnt <= '0;
      r_state <= RUN;
      r_data <= '0;
    end else begin
      r_sync1 <= bus.Button;
      r_sync2 <= r_sync1;
      r_db <= w_flip ? ~r_db : r_db;
      r_press <= w_flip && r_db;
      r_cnt <= (!w_diff || w_flip) ? '0 : (r_cnt == CW'(DEBOUNCE_CYCLES)) ? r_cnt : r_cnt + CW'(1);
      r_state <= w_next;
      if (r_state == WAIT && r_press) r_data <= w_ext;
    end
  end
  always_comb begin
    w_next = r_state;
    bus.ClockEnable = 1'b1;
    bus.InValid = 1'b0;
    bus.Waiting = 1'b0;
    bus.Halted = 1'b0;
    case (r_state)
      RUN: begin
        w_next = bus.Halt ? HALTED : bus.In ? WAIT : RUN;
        bus.ClockEnable = !(bus.In || bus.Halt);
        bus.Waiting = bus.In && !bus.Halt;
        bus.Halted = bus.Halt;
      end
      WAIT: begin
        w_next = r_press ? COMMIT : WAIT;
        bus.ClockEnable = 1'b0;
        bus.Waiting = 1'b1;
      end
      COMMIT: begin
        w_next = RUN;
        bus.InValid = 1'b1;
      end
      default: begin
        bus.ClockEnable = 1'b0;
        bus.Halted = 1'b1;
      end
    endcase
  end
endmodule
